// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the core MEM stage and a debug/loader port
// Optional build macro DMEM_ARB_FAIRNESS_EN enables the debug anti-starvation wait counter.
module dmem_port_arbiter #(
   parameter int MAX_WAIT = 8,
   parameter int MAX_LOCK = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [63:0] core_addr,
   input  logic [63:0] core_wdata,
   output logic [63:0] core_rdata,
   output logic        core_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic        dbg_lock,
   input  logic [63:0] dbg_addr,
   input  logic [63:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic [63:0] dbg_rdata,
   output logic        dbg_rvalid,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_rdata
);
   typedef enum logic {ARB_IDLE, ARB_LOCK} state_t;
   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_lock_cnt;
   logic        w_fair;
   logic        w_dbg_win;
   logic [63:0] r_dbg_rdata;
   logic        r_dbg_rvalid;

`ifdef DMEM_ARB_FAIRNESS_EN
   logic [7:0] r_wait_cnt;
   assign w_fair = r_wait_cnt == 8'(MAX_WAIT);
   // count consecutive denied debug cycles, saturating at the forcing threshold
   always_ff @(posedge clock)
      if (reset || w_dbg_win || !dbg_req) r_wait_cnt <= '0;
      else if (!w_fair) r_wait_cnt <= r_wait_cnt + 8'd1;
`else
   assign w_fair = 1'b0;
`endif

   assign w_dbg_win = dbg_req & (!core_req | (r_state == ARB_LOCK && r_lock_cnt < 8'(MAX_LOCK)) | w_fair);

   // arbitration state register
   always_ff @(posedge clock)
      if (reset) r_state <= ARB_IDLE;
      else r_state <= w_next;

   // lock is held only while debug keeps winning with dbg_lock set; any denial (forced core slot) drops it
   always_comb w_next = (w_dbg_win && dbg_lock) ? ARB_LOCK : ARB_IDLE;

   // memory mux and handshake outputs; core traffic passes straight through when it owns the port
   always_comb begin
      dbg_gnt    = w_dbg_win;
      core_stall = core_req & w_dbg_win;
      core_rdata = mem_rdata;
      mem_addr   = w_dbg_win ? dbg_addr : core_req ? core_addr : '0;
      mem_wdata  = w_dbg_win ? dbg_wdata : core_req ? core_wdata : '0;
      mem_write  = w_dbg_win ? dbg_we : core_req & core_we;
      mem_read   = w_dbg_win ? !dbg_we : core_req & !core_we;
   end

   // locked beats taken against a requesting core, reset whenever the lock is released
   always_ff @(posedge clock)
      if (reset || w_next == ARB_IDLE) r_lock_cnt <= '0;
      else if (r_state == ARB_LOCK && w_dbg_win && core_req) r_lock_cnt <= r_lock_cnt + 8'd1;

   // capture debug read data one cycle after the granted beat
   always_ff @(posedge clock)
      if (reset) begin
         r_dbg_rdata  <= '0;
         r_dbg_rvalid <= 1'b0;
      end else begin
         r_dbg_rvalid <= w_dbg_win & !dbg_we;
         if (w_dbg_win && !dbg_we) r_dbg_rdata <= mem_rdata;
      end

   assign dbg_rdata  = r_dbg_rdata;
   assign dbg_rvalid = r_dbg_rvalid;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table plus read-data scoreboard for dmem_port_arbiter
module tb_dmem_port_arbiter;
   localparam bit FAIR =
`ifdef DMEM_ARB_FAIRNESS_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct {
      logic        cr, cw;
      logic [63:0] ca, cd;
      logic        dr, dw, dl;
      logic [63:0] da, dd;
      logic        eg, es, emw, emr;
      logic [63:0] ema, emd;
   } vec_t;

   logic        clock = 0, reset = 1;
   logic        core_req = 0, core_we = 0, dbg_req = 0, dbg_we = 0, dbg_lock = 0;
   logic [63:0] core_addr = 0, core_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
   logic [63:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        core_stall, dbg_gnt, dbg_rvalid, mem_write, mem_read;
   logic [63:0] ram [256];
   logic [63:0] model [256];
   logic [63:0] sb_q [$];
   int checks = 0, errors = 0;
   vec_t tbl [14];

   dmem_port_arbiter #(.MAX_WAIT(3), .MAX_LOCK(2)) dut (
      .clock(clock), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;
   assign mem_rdata = ram[mem_addr[7:0]];
   always @(posedge clock) if (mem_write) ram[mem_addr[7:0]] <= mem_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic cr, logic cw, logic [63:0] ca, logic [63:0] cd,
                               logic dr, logic dw, logic dl, logic [63:0] da, logic [63:0] dd,
                               logic eg, logic es, logic emw, logic emr, logic [63:0] ema, logic [63:0] emd);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
      v.eg = eg; v.es = es; v.emw = emw; v.emr = emr; v.ema = ema; v.emd = emd;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
      dbg_req = v.dr; dbg_we = v.dw; dbg_lock = v.dl; dbg_addr = v.da; dbg_wdata = v.dd;
   endtask

   task automatic step(input string tag, input vec_t v);
      logic pend;
      drive(v);
      #3;
      chk({tag, ".gnt"}, 64'(dbg_gnt), 64'(v.eg));
      chk({tag, ".stall"}, 64'(core_stall), 64'(v.es));
      chk({tag, ".mem_write"}, 64'(mem_write), 64'(v.emw));
      chk({tag, ".mem_read"}, 64'(mem_read), 64'(v.emr));
      chk({tag, ".mem_addr"}, mem_addr, v.ema);
      chk({tag, ".mem_wdata"}, mem_wdata, v.emd);
      if (v.cr && !v.cw && !v.eg) chk({tag, ".core_rdata"}, core_rdata, model[v.ca[7:0]]);
      pend = v.eg & !v.dw;
      if (pend) sb_q.push_back(model[v.da[7:0]]);
      if (v.emw) model[v.ema[7:0]] = v.emd;
      @(posedge clock); #1;
      chk({tag, ".rvalid"}, 64'(dbg_rvalid), 64'(pend));
      if (dbg_rvalid) begin
         if (sb_q.size() == 0) chk({tag, ".sb_underflow"}, 64'(1), 64'(0));
         else chk({tag, ".rdata"}, dbg_rdata, sb_q.pop_front());
      end
   endtask

   initial begin
      vec_t idle, v;
      idle = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
      tbl[0]  = idle;
      tbl[1]  = mk(1,1,'h10,'hAB, 0,0,0,0,0,      0,0,1,0,'h10,'hAB);
      tbl[2]  = mk(1,0,'h10,0,    0,0,0,0,0,      0,0,0,1,'h10,0);
      tbl[3]  = mk(0,0,0,0,       1,1,0,'h20,'h55, 1,0,1,0,'h20,'h55);
      tbl[4]  = mk(0,0,0,0,       1,0,0,'h20,0,   1,0,0,1,'h20,0);
      tbl[5]  = idle;
      tbl[6]  = mk(1,0,'h10,0,    1,0,0,'h20,0,   0,0,0,1,'h10,0);
      tbl[7]  = idle;
      tbl[8]  = mk(0,0,0,0,       1,0,1,'h20,0,   1,0,0,1,'h20,0);
      tbl[9]  = mk(1,0,'h10,0,    1,0,1,'h20,0,   1,1,0,1,'h20,0);
      tbl[10] = tbl[9];
      tbl[11] = mk(1,0,'h10,0,    1,0,1,'h20,0,   0,0,0,1,'h10,0);
      tbl[12] = mk(1,1,'h30,'h77, 0,0,1,0,0,      0,0,1,0,'h30,'h77);
      tbl[13] = idle;

      repeat (2) @(posedge clock);
      #1;
      dbg_req = 1;
      #1 chk("rst.gnt_dbg_only", 64'(dbg_gnt), 64'(1));
      core_req = 1;
      #1 chk("rst.gnt_contended", 64'(dbg_gnt), 64'(0));
      chk("rst.rvalid", 64'(dbg_rvalid), 64'(0));
      chk("rst.rdata", dbg_rdata, 64'(0));
      drive(idle);
      @(posedge clock); #1;
      reset = 0;

      for (int i = 0; i < 14; i++) step($sformatf("vec%0d", i), tbl[i]);

      for (int i = 0; i < 20; i++) begin
         logic g;
         g = FAIR && (i % 4 == 3);
         v = mk(1,0,'h10,0, 1,0,0,'h20,0, g,g,0,1, g ? 64'h20 : 64'h10, 0);
         step($sformatf("cont%0d", i), v);
      end
      step("cont_end", idle);

      step("lk_enter", mk(0,0,0,0, 1,0,1,'h20,0, 1,0,0,1,'h20,0));
      step("lk_beat", mk(1,0,'h10,0, 1,0,1,'h20,0, 1,1,0,1,'h20,0));
      reset = 1;
      #3;
      @(posedge clock); #1;
      chk("rstlk.rvalid", 64'(dbg_rvalid), 64'(0));
      chk("rstlk.rdata", dbg_rdata, 64'(0));
      reset = 0;
      #3;
      chk("rstlk.gnt", 64'(dbg_gnt), 64'(0));
      chk("rstlk.stall", 64'(core_stall), 64'(0));
      chk("rstlk.mem_addr", mem_addr, 64'h10);
      @(posedge clock); #1;
      chk("rstlk.rvalid_after", 64'(dbg_rvalid), 64'(0));
      drive(idle);
      @(posedge clock); #1;
      chk("sb_empty", 64'(sb_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
